// File: rtl/sliding_tile_driver.sv
// sliding_tile_driver
//   Buffers a host-supplied list of moves for the 3x3 sliding-tile board and
//   plays them back one per cycle. Tracks its own copy of the blank location
//   so that only legal moves reach the board; illegal moves are dropped and
//   counted.
//
// Ports
//   clk, reset     : clock; synchronous active-high reset
//   in_valid/in_dir: host offers a move (00 LEFT, 01 RIGHT, 10 UP, 11 DOWN)
//   in_ready       : FIFO accepts a move (IDLE and not full)
//   start          : begin playback of the buffered moves
//   dir_out        : direction to the board, held between legal moves
//   dir_valid      : dir_out is a legal move this cycle
//   busy           : playback in progress
//   done           : one-cycle pulse when playback ends
//   blank_row/col  : tracked blank location (row 0 = top, col 0 = left)
//   move_count     : legal moves issued since reset, saturating
//   illegal_count  : moves dropped since reset, saturating at 15
module sliding_tile_driver #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       in_dir,
    output logic             in_ready,
    input  logic             start,
    output logic [1:0]       dir_out,
    output logic             dir_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       blank_row,
    output logic [1:0]       blank_col,
    output logic [CNT_W-1:0] move_count,
    output logic [3:0]       illegal_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mem_q [DEPTH];
    logic [1:0]         mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [1:0]         dir_out_q, dir_out_d;
    logic               dir_valid_q, dir_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         row_q, row_d;
    logic [1:0]         col_q, col_d;
    logic [CNT_W-1:0]   move_count_q, move_count_d;
    logic [3:0]         illegal_count_q, illegal_count_d;

    logic               push;
    logic [1:0]         head;
    logic               head_legal;
    logic [1:0]         next_row;
    logic [1:0]         next_col;

    assign in_ready = (state_q == S_IDLE) && (occ_q != OCC_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    // Legality of the head entry against the tracked blank, plus the blank
    // location it would lead to.
    always_comb begin
        head_legal = 1'b0;
        next_row   = row_q;
        next_col   = col_q;
        unique case (head)
            2'b00: begin head_legal = (col_q != 2'd0); next_col = col_q - 2'd1; end
            2'b01: begin head_legal = (col_q != 2'd2); next_col = col_q + 2'd1; end
            2'b10: begin head_legal = (row_q != 2'd0); next_row = row_q - 2'd1; end
            2'b11: begin head_legal = (row_q != 2'd2); next_row = row_q + 2'd1; end
        endcase
    end

    always_comb begin
        state_d         = state_q;
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        occ_d           = occ_q;
        dir_out_d       = dir_out_q;
        dir_valid_d     = 1'b0;
        busy_d          = 1'b0;
        done_d          = 1'b0;
        row_d           = row_q;
        col_d           = col_q;
        move_count_d    = move_count_q;
        illegal_count_d = illegal_count_q;

        // Pushes only happen in IDLE and pops only in PLAY, so occupancy
        // never sees both in the same cycle.
        if (push) begin
            mem_d[wr_ptr_q] = in_dir;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            occ_d           = occ_q + OCC_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PLAY;
                    busy_d  = 1'b1;
                end
            end
            S_PLAY: begin
                if (occ_q != '0) begin
                    busy_d   = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    occ_d    = occ_q - OCC_W'(1);
                    if (head_legal) begin
                        dir_out_d   = head;
                        dir_valid_d = 1'b1;
                        row_d       = next_row;
                        col_d       = next_col;
                        if (move_count_q != '1)
                            move_count_d = move_count_q + CNT_W'(1);
                    end else if (illegal_count_q != '1) begin
                        illegal_count_d = illegal_count_q + 4'd1;
                    end
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            dir_out_q       <= '0;
            dir_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            row_q           <= 2'd2;
            col_q           <= 2'd2;
            move_count_q    <= '0;
            illegal_count_q <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            dir_out_q       <= dir_out_d;
            dir_valid_q     <= dir_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            row_q           <= row_d;
            col_q           <= col_d;
            move_count_q    <= move_count_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign dir_out       = dir_out_q;
    assign dir_valid     = dir_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign blank_row     = row_q;
    assign blank_col     = col_q;
    assign move_count    = move_count_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_sliding_tile_driver.sv
// tb_sliding_tile_driver
//   Self-checking bench for sliding_tile_driver: a table of hand-worked move
//   lists with known final blank/counter values, hand-written reset and
//   saturation sequences, and randomized loads compared cycle by cycle
//   against a board-position reference model.
module tb_sliding_tile_driver;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [1:0]       in_dir;
    logic             in_ready;
    logic             start;
    logic [1:0]       dir_out;
    logic             dir_valid;
    logic             busy;
    logic             done;
    logic [1:0]       blank_row;
    logic [1:0]       blank_col;
    logic [CNT_W-1:0] move_count;
    logic [3:0]       illegal_count;

    sliding_tile_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_dir        (in_dir),
        .in_ready      (in_ready),
        .start         (start),
        .dir_out       (dir_out),
        .dir_valid     (dir_valid),
        .busy          (busy),
        .done          (done),
        .blank_row     (blank_row),
        .blank_col     (blank_col),
        .move_count    (move_count),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: board position as plain integers.
    int         m_row, m_col, m_mc, m_ic;
    logic [1:0] m_dir;
    logic [1:0] fifo_q [$];
    logic [1:0] stim   [$];

    typedef struct {
        int          n;
        logic [17:0] dirs;     // entry i in dirs[2*i +: 2]
        int          exp_mc;
        int          exp_ic;
        int          exp_row;
        int          exp_col;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        fifo_q.delete();
        m_row = 2; m_col = 2; m_mc = 0; m_ic = 0; m_dir = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_dir = 2'b00; start = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        check("rst_dir_valid", int'(dir_valid), 0);
        check("rst_dir_out", int'(dir_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_row", int'(blank_row), 2);
        check("rst_col", int'(blank_col), 2);
        check("rst_mc", int'(move_count), 0);
        check("rst_ic", int'(illegal_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
    endtask

    // Pushes everything in stim, starts playback (optionally together with
    // the last push) and checks every cycle through the done pulse.
    task automatic run_load(input bit start_with_last);
        int  n;
        int  dr, dc, nr, nc;
        bit  legal;
        bit  started = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            in_valid = 1'b1;
            in_dir   = stim[i];
            if (start_with_last && i == stim.size() - 1) begin
                start   = 1'b1;
                started = 1'b1;
            end
            check("in_ready", int'(in_ready), int'(fifo_q.size() < DEPTH));
            if (fifo_q.size() < DEPTH) fifo_q.push_back(stim[i]);
            tick();
        end
        in_valid = 1'b0;
        if (!started) begin
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        check("play_busy", int'(busy), 1);
        check("play_in_ready", int'(in_ready), 0);
        check("play_dir_valid0", int'(dir_valid), 0);
        n = fifo_q.size();
        for (int i = 0; i < n; i++) begin
            logic [1:0] d;
            d  = fifo_q.pop_front();
            dr = 0; dc = 0;
            case (d)
                2'b00: dc = -1;
                2'b01: dc = 1;
                2'b10: dr = -1;
                default: dr = 1;
            endcase
            nr = m_row + dr; nc = m_col + dc;
            legal = (nr >= 0 && nr <= 2 && nc >= 0 && nc <= 2);
            if (legal) begin
                m_row = nr; m_col = nc; m_dir = d;
                if (m_mc < (1 << CNT_W) - 1) m_mc++;
            end else if (m_ic < 15) begin
                m_ic++;
            end
            tick();
            check("dir_valid", int'(dir_valid), int'(legal));
            check("dir_out", int'(dir_out), int'(m_dir));
            check("busy", int'(busy), 1);
            check("done_low", int'(done), 0);
            check("blank_row", int'(blank_row), m_row);
            check("blank_col", int'(blank_col), m_col);
            check("move_count", int'(move_count), m_mc);
            check("illegal_count", int'(illegal_count), m_ic);
        end
        tick();
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 0);
        check("done_dir_valid", int'(dir_valid), 0);
        check("done_dir_out", int'(dir_out), int'(m_dir));
        tick();
        check("done_end", int'(done), 0);
        check("idle_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_dir = 2'b00; start = 1'b0;

        // LEFT LEFT UP UP
        vecs[0] = '{4, 18'b10_10_00_00, 4, 0, 0, 0};
        // RIGHT DOWN LEFT
        vecs[1] = '{3, 18'b00_11_01, 1, 2, 2, 1};
        // UP UP UP LEFT
        vecs[2] = '{4, 18'b00_10_10_10, 3, 1, 0, 1};
        // empty FIFO
        vecs[3] = '{0, 18'b0, 0, 0, 2, 2};
        // LEFT UP RIGHT DOWN
        vecs[4] = '{4, 18'b11_01_10_00, 4, 0, 2, 2};
        // L L U U R R D D + 9th LEFT refused when full
        vecs[5] = '{9, 18'b00_11_11_01_01_10_10_00_00, 8, 0, 2, 2};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            stim.delete();
            for (int i = 0; i < vecs[v].n; i++) stim.push_back(vecs[v].dirs[2*i +: 2]);
            run_load(1'b0);
            check("vec_mc", int'(move_count), vecs[v].exp_mc);
            check("vec_ic", int'(illegal_count), vecs[v].exp_ic);
            check("vec_row", int'(blank_row), vecs[v].exp_row);
            check("vec_col", int'(blank_col), vecs[v].exp_col);
        end

        // Reset during playback with three entries still queued.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_dir   = (i % 2 == 0) ? 2'b00 : 2'b10;
            tick();
        end
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midplay_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_dir_valid", int'(dir_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_row", int'(blank_row), 2);
        check("midrst_col", int'(blank_col), 2);
        check("midrst_mc", int'(move_count), 0);
        check("midrst_ic", int'(illegal_count), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        model_reset();
        stim.delete();
        run_load(1'b0);   // FIFO must be empty: straight to done

        // Illegal-count saturation: 16 DOWN moves with the blank on row 2.
        do_reset();
        for (int l = 0; l < 2; l++) begin
            stim.delete();
            for (int i = 0; i < 8; i++) stim.push_back(2'b11);
            run_load(1'b0);
        end
        check("ic_saturated", int'(illegal_count), 15);
        check("ic_sat_mc", int'(move_count), 0);

        // Randomized loads without intervening resets (reaches move_count
        // saturation as well).
        do_reset();
        for (int r = 0; r < 140; r++) begin
            int n;
            n = $urandom_range(0, DEPTH);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(2'($urandom_range(0, 3)));
            run_load(n > 0 && $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
